// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: resolves hazard stalls, memory freezes and branch
// flushes into per-stage enable/flush/bubble controls for a 5-stage pipeline.
// Control outputs are combinational from the registered state and current
// inputs; state, consecutive counters, sticky flags and perf counters are
// registered.
// Optional build macro: STALL_PERF_CNT_EN adds the saturating stall/flush
// cycle counters; without it stall_cnt and flush_cnt are tied to zero.
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_STALL   = 4,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_req,
    input  logic             flush_req,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clear_flags,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_enable,
    output logic             id_ex_bubble,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic [1:0]       ctrl_state,
    output logic             stall_overflow,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL      = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH_PEND = 2'd3
    } state_e;

    // hz counter must be able to hold MAX_STALL+1 to detect "exceeded"
    localparam int unsigned HZ_W = $clog2(MAX_STALL + 2);
    localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [HZ_W-1:0] HZ_MAX = HZ_W'(MAX_STALL);
    localparam logic [HZ_W-1:0] HZ_SAT = HZ_W'(MAX_STALL + 1);
    localparam logic [WT_W-1:0] WT_SAT = WT_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [HZ_W-1:0] hz_cnt_q, hz_cnt_d, hz_inc;
    logic [WT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic            stall_ovf_q, stall_ovf_d;
    logic            mem_to_q, mem_to_d;
    logic            mem_busy;
    logic            flush_now;

    // Saturating increments of the consecutive-event counters
    always_comb begin
        hz_inc   = (hz_cnt_q == HZ_SAT) ? hz_cnt_q : hz_cnt_q + HZ_W'(1);
        wait_inc = (wait_cnt_q == WT_SAT) ? wait_cnt_q : wait_cnt_q + WT_W'(1);
    end

    // Priority resolution: memory freeze > flush (new or deferred) > hazard > run
    always_comb begin
        state_d       = ST_RUN;
        hz_cnt_d      = '0;
        wait_cnt_d    = '0;
        stall_ovf_d   = stall_ovf_q;
        mem_to_d      = mem_to_q;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;

        mem_busy  = dmem_req & ~dmem_ready;
        flush_now = flush_req | (state_q == ST_FLUSH_PEND);

        if (mem_busy) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            state_d       = flush_now ? ST_FLUSH_PEND : ST_MEM_WAIT;
            wait_cnt_d    = wait_inc;
            hz_cnt_d      = hazard_req ? hz_cnt_q : '0;
            if (wait_inc == WT_SAT) begin
                mem_to_d = 1'b1;
            end
        end else if (flush_now) begin
            // squash IF/ID and ID/EX; any pending hazard belongs to a squashed op
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
        end else if (hazard_req) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = ST_STALL;
            hz_cnt_d     = hz_inc;
            if (hz_inc > HZ_MAX) begin
                stall_ovf_d = 1'b1;
            end
        end

        if (clear_flags) begin
            stall_ovf_d = 1'b0;
            mem_to_d    = 1'b0;
        end

        // reset forces every stage closed with flush/bubble asserted
        if (rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_enable  = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end
    end

    // State, consecutive counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hz_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            stall_ovf_q <= 1'b0;
            mem_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hz_cnt_q    <= hz_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_ovf_q <= stall_ovf_d;
            mem_to_q    <= mem_to_d;
        end
    end

    assign ctrl_state     = state_q;
    assign stall_overflow = stall_ovf_q;
    assign mem_timeout    = mem_to_q;

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating perf counters; a clear request overrides same-cycle events
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clear_flags) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_enable && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with an expected-value scoreboard.
// Control words are packed {pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
// ex_mem_en, mem_wb_en}. Counter expectations follow STALL_PERF_CNT_EN.
module tb_pipeline_stall_ctrl;

    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] C_NORM  = 7'b1101011;
    localparam logic [6:0] C_STALL = 7'b0001111;
    localparam logic [6:0] C_FLUSH = 7'b1111111;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b0010100;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_STL = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;
    localparam logic [1:0] S_FP  = 2'd3;

    logic             clk;
    logic             rst;
    logic             hazard_req, flush_req, dmem_req, dmem_ready, clear_flags;
    logic             pc_enable, if_id_enable, if_id_flush, id_ex_enable;
    logic             id_ex_bubble, ex_mem_enable, mem_wb_enable;
    logic [1:0]       ctrl_state;
    logic             stall_overflow, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(4), .MEM_TIMEOUT(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_req     (hazard_req),
        .flush_req      (flush_req),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .clear_flags    (clear_flags),
        .pc_enable      (pc_enable),
        .if_id_enable   (if_id_enable),
        .if_id_flush    (if_id_flush),
        .id_ex_enable   (id_ex_enable),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_enable  (ex_mem_enable),
        .mem_wb_enable  (mem_wb_enable),
        .ctrl_state     (ctrl_state),
        .stall_overflow (stall_overflow),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]       ctl;
        logic [1:0]       st;
        logic             sov;
        logic             mto;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // reference model of the registered observables
    int               hz_m, wt_m;
    logic             sov_m, mto_m;
    logic [CNT_W-1:0] sc_m, fc_m;

    task automatic model_reset();
        hz_m  = 0;
        wt_m  = 0;
        sov_m = 1'b0;
        mto_m = 1'b0;
        sc_m  = '0;
        fc_m  = '0;
    endtask

    task automatic push_exp(input logic [6:0] ctl, input logic [1:0] st);
        exp_t e;
        e.ctl = ctl;
        e.st  = st;
        e.sov = sov_m;
        e.mto = mto_m;
`ifdef STALL_PERF_CNT_EN
        e.sc  = sc_m;
        e.fc  = fc_m;
`else
        e.sc  = '0;
        e.fc  = '0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        logic [6:0] ctl;
        if (sb_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $error("FAIL %s_empty observed=0 expected=1", tag);
            return;
        end
        e   = sb_q.pop_front();
        ctl = {pc_enable, if_id_enable, if_id_flush, id_ex_enable,
               id_ex_bubble, ex_mem_enable, mem_wb_enable};
        chk({tag, "_ctl"}, 32'(ctl), 32'(e.ctl));
        chk({tag, "_state"}, 32'(ctrl_state), 32'(e.st));
        chk({tag, "_sovf"}, 32'(stall_overflow), 32'(e.sov));
        chk({tag, "_mto"}, 32'(mem_timeout), 32'(e.mto));
        chk({tag, "_scnt"}, 32'(stall_cnt), 32'(e.sc));
        chk({tag, "_fcnt"}, 32'(flush_cnt), 32'(e.fc));
    endtask

    // drive one cycle at the negedge, check before the posedge, advance model
    task automatic step(input string tag, input logic h, input logic f,
                        input logic dr, input logic rdy, input logic clr,
                        input logic [6:0] ctl, input logic [1:0] st);
        logic frz;
        hazard_req  = h;
        flush_req   = f;
        dmem_req    = dr;
        dmem_ready  = rdy;
        clear_flags = clr;
        push_exp(ctl, st);
        #4;
        pop_and_check(tag);
        frz = (ctl == C_FRZ);
        if (frz) wt_m++; else wt_m = 0;
        if (ctl == C_STALL) hz_m++;
        else if (!h || ctl == C_FLUSH) hz_m = 0;
        if (clr) begin
            sov_m = 1'b0;
            mto_m = 1'b0;
            sc_m  = '0;
            fc_m  = '0;
        end else begin
            if (frz && wt_m >= 64) mto_m = 1'b1;
            if (ctl == C_STALL && hz_m > 4) sov_m = 1'b1;
            if (!ctl[6] && sc_m != '1) sc_m = sc_m + CNT_W'(1);
            if (ctl[4] && fc_m != '1) fc_m = fc_m + CNT_W'(1);
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        hazard_req  = 1'b0;
        flush_req   = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b0;
        clear_flags = 1'b0;
        model_reset();

        #3;
        push_exp(C_RST, S_RUN);
        pop_and_check("reset");

        @(negedge clk);
        rst = 1'b0;

        step("run0", 0, 0, 0, 0, 0, C_NORM, S_RUN);

        // single hazard cycle
        step("hz1", 1, 0, 0, 0, 0, C_STALL, S_RUN);
        step("hz1_after", 0, 0, 0, 0, 0, C_NORM, S_STL);

        // flush beats hazard
        step("hzfl", 1, 1, 0, 0, 0, C_FLUSH, S_RUN);
        step("hzfl_after", 0, 0, 0, 0, 0, C_NORM, S_RUN);

        // flush deferred by a 3-cycle memory wait
        step("mw_fl0", 0, 1, 1, 0, 0, C_FRZ, S_RUN);
        step("mw_fl1", 0, 0, 1, 0, 0, C_FRZ, S_FP);
        step("mw_fl2", 0, 0, 1, 0, 0, C_FRZ, S_FP);
        step("mw_flrdy", 0, 0, 1, 1, 0, C_FLUSH, S_FP);
        step("mw_flrun", 0, 0, 0, 0, 0, C_NORM, S_RUN);

        // hazard held 6 cycles trips stall_overflow after the 5th
        for (int i = 0; i < 6; i++) begin
            step($sformatf("hzlong%0d", i), 1, 0, 0, 0, 0, C_STALL,
                 (i == 0) ? S_RUN : S_STL);
        end
        step("hzlong_end", 0, 0, 0, 0, 0, C_NORM, S_STL);
        step("clr", 0, 0, 0, 0, 1, C_NORM, S_RUN);
        step("clr_hz", 1, 0, 0, 0, 1, C_STALL, S_RUN);
        step("clr_after", 0, 0, 0, 0, 0, C_NORM, S_STL);

        // memory wait exit straight into a hazard stall
        step("mw_hz0", 0, 0, 1, 0, 0, C_FRZ, S_RUN);
        step("mw_hz1", 1, 0, 1, 1, 0, C_STALL, S_MW);
        step("mw_hz2", 0, 0, 0, 0, 0, C_NORM, S_STL);

        // long memory wait sets mem_timeout at the 64th wait cycle
        for (int i = 0; i < 70; i++) begin
            step($sformatf("mto%0d", i), 0, 0, 1, 0, 0, C_FRZ,
                 (i == 0) ? S_RUN : S_MW);
        end

        // asynchronous reset mid-wait
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp(C_RST, S_RUN);
        pop_and_check("async_rst");
        @(negedge clk);
        rst      = 1'b0;
        dmem_req = 1'b0;
        step("post_rst", 0, 0, 0, 0, 0, C_NORM, S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Pipeline control sequencer that consumes the hazard unit's stall request, the EX-stage branch-flush request and the data-memory handshake. It drives registered-state-based enables, flush and bubble controls to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It is the single point that resolves conflicting stall, freeze and flush events. It also counts stall and flush cycles and raises sticky error flags.

Parameters:
CNT_W, 16, width of the saturating stall and flush counters
MAX_STALL, 4, maximum consecutive hazard stall cycles before stall_overflow is set (range 1..255)
MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before mem_timeout is set (range 1..1023)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
hazard_req  input  1  load-use stall request from the hazard unit (selector_hazard)
flush_req  input  1  branch/jump taken in EX; squash IF/ID and ID/EX
dmem_req  input  1  MEM stage has a data-memory access in flight
dmem_ready  input  1  data memory completes the access this cycle
clear_flags  input  1  synchronous clear of the sticky flags and counters
pc_enable  output  1  PC register load enable
if_id_enable  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID loads a NOP
id_ex_enable  output  1  ID/EX register load enable
id_ex_bubble  output  1  ID/EX loads zeroed control (bubble)
ex_mem_enable  output  1  EX/MEM register load enable
mem_wb_enable  output  1  MEM/WB register load enable
ctrl_state  output  2  current state: 0 RUN, 1 STALL, 2 MEM_WAIT, 3 FLUSH_PEND
stall_overflow  output  1  sticky: hazard_req was held for more than MAX_STALL consecutive cycles
mem_timeout  output  1  sticky: memory wait exceeded MEM_TIMEOUT cycles
stall_cnt  output  CNT_W  saturating count of cycles with pc_enable=0
flush_cnt  output  CNT_W  saturating count of cycles with if_id_flush=1

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. The state, counters and flags are registered.
- While rst=1: state=RUN, all enables=0, if_id_flush=1, id_ex_bubble=1, flags=0, counters=0, internal consecutive counters=0.
- mem_busy = dmem_req & ~dmem_ready. Per-cycle priority: mem_busy > pending/current flush > hazard_req > normal.
- Freeze (mem_busy=1): all five enables=0, if_id_flush=0, id_ex_bubble=0.
  - If flush_req=1 in the same cycle, it is latched and the state goes to FLUSH_PEND.
  - Otherwise the state goes to MEM_WAIT.
  - wait_cnt increments each freeze cycle. When it reaches MEM_TIMEOUT, mem_timeout is set. wait_cnt clears on the first non-busy cycle.
- Flush (flush_req=1, or state=FLUSH_PEND, with mem_busy=0):
  - pc_enable=1, if_id_enable=1, if_id_flush=1, id_ex_enable=1, id_ex_bubble=1, ex_mem_enable=1, mem_wb_enable=1.
  - hazard_req is ignored (the stalling instruction is squashed).
  - Next state is RUN. The pending flag clears.
- Stall (hazard_req=1, no flush, mem_busy=0):
  - pc_enable=0, if_id_enable=0, id_ex_enable=1, id_ex_bubble=1, ex_mem_enable=1, mem_wb_enable=1, if_id_flush=0.
  - Next state is STALL.
  - hz_cnt increments. When it exceeds MAX_STALL, stall_overflow is set. hz_cnt clears on any cycle with hazard_req=0.
- Normal (no event): all enables=1, flush=0, bubble=0, next state RUN.
- MEM_WAIT and STALL have no memory of their own. On exit, behaviour follows the priority rule above on that cycle's inputs.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_flags=1 zeroes both flags and both counters on the next edge. It does not affect state or a pending flush. If an event occurs in the same cycle, the clear wins.
- Zero latency: the control response is in the same cycle as the request. The only delayed effect is a flush deferred by memory wait, which is applied in the first non-busy cycle.

Optional Feature:
STALL_PERF_CNT_EN: when defined, stall_cnt and flush_cnt are implemented as described. When undefined, no counter registers exist and both outputs are tied to 0. Flags and control behaviour are identical in both builds.

Test Plan:
- Reset release, all inputs 0 -> first cycle all enables=1, flush=0, bubble=0, ctrl_state=0.
- hazard_req=1 for 1 cycle -> that cycle pc_enable=0, if_id_enable=0, id_ex_bubble=1, ctrl_state=1 next cycle; stall_cnt=1; stall_overflow=0.
- hazard_req and flush_req both 1 -> if_id_flush=1, id_ex_bubble=1, pc_enable=1; stall_cnt unchanged; flush_cnt=1.
- dmem_req=1, dmem_ready=0 for 3 cycles with flush_req=1 in cycle 1 -> 3 cycles all enables=0; ctrl_state=3; 4th cycle (ready) if_id_flush=1, then RUN.
- hazard_req held 6 cycles with MAX_STALL=4 -> stall_overflow=1 after the 5th cycle and stays 1; clear_flags=1 -> flags=0, stall_cnt=0.
- Memory wait of 70 cycles with MEM_TIMEOUT=64 -> mem_timeout=1 at the 64th wait cycle; rst pulse mid-wait -> all outputs return to reset values asynchronously.
